// File: rtl/line_delay_buffer_if.sv
// ---------------------------------------------------------------------------
// line_delay_buffer_if
//   Bundles the sample stream, configuration and status signals of
//   line_delay_buffer.
//
//   Signals
//     in_valid    master->slave  sample strobe (no backpressure)
//     in_data     master->slave  CHANNELS*WIDTH packed samples, lane k at [k*WIDTH +: WIDTH]
//     cfg_load    master->slave  one-cycle strobe: latch delay_len, restart filling
//     delay_len   master->slave  requested delay in accepted samples
//     out_valid   slave->master  one cycle per produced delayed sample
//     out_data    slave->master  delayed samples, same packing as in_data
//     fill_count  slave->master  accepted samples held toward the active delay
//     filling     slave->master  high while the buffer is still filling
//
//   Handshake: there is no ready. A sample is accepted on every rising clk
//   edge where in_valid=1. out_valid is a pure strobe; the consumer must take
//   out_data in the cycle out_valid=1, and out_data holds otherwise.
// ---------------------------------------------------------------------------
interface line_delay_buffer_if #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 1,
  parameter int MAX_DEPTH = 16
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic                      in_valid;
  logic [WIDTH*CHANNELS-1:0] in_data;
  logic                      cfg_load;
  logic [DW-1:0]             delay_len;
  logic                      out_valid;
  logic [WIDTH*CHANNELS-1:0] out_data;
  logic [DW-1:0]             fill_count;
  logic                      filling;

  modport master (
    output in_valid, in_data, cfg_load, delay_len,
    input  out_valid, out_data, fill_count, filling
  );

  modport slave (
    input  in_valid, in_data, cfg_load, delay_len,
    output out_valid, out_data, fill_count, filling
  );
endinterface

// File: rtl/line_delay_buffer.sv
// ---------------------------------------------------------------------------
// line_delay_buffer
//   Programmable sample delay line. Every accepted multi-channel sample is
//   written into a MAX_DEPTH-entry circular buffer; once D samples have been
//   collected since the last reset or cfg_load, each further accept emits the
//   sample accepted exactly D accepts earlier, one clock after the accept.
//
//   Ports
//     clk    clock, all state changes on the rising edge
//     reset  asynchronous, active-high reset
//     bus    line_delay_buffer_if.slave (stream in, delayed stream out,
//            configuration strobe, fill status; filling mirrors the FSM state)
// ---------------------------------------------------------------------------
module line_delay_buffer #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 1,
  parameter int MAX_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  line_delay_buffer_if.slave    bus
);

  localparam int DW     = $clog2(MAX_DEPTH + 1);
  localparam int PW     = $clog2(MAX_DEPTH);
  localparam int AW     = DW + 1;
  localparam int DATA_W = WIDTH * CHANNELS;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       d_q, d_d;
  logic [DW-1:0]       fill_q, fill_d;
  logic [DW-1:0]       fill_inc;
  logic [DW-1:0]       d_clamped;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [PW-1:0]       rd_addr;
  logic [AW-1:0]       wr_ext, d_ext, rd_ext;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                mem_we;

  // Storage is deliberately not reset: FILL gating guarantees no entry is
  // read before it has been written under the current configuration.
  logic [DATA_W-1:0]   mem [MAX_DEPTH];

  // Delay clamp applied at latch time: 0 behaves as 1, oversize as MAX_DEPTH.
  always_comb begin
    d_clamped = bus.delay_len;
    if (bus.delay_len == '0) begin
      d_clamped = DW'(1);
    end else if (bus.delay_len > DW'(MAX_DEPTH)) begin
      d_clamped = DW'(MAX_DEPTH);
    end
  end

  // Read address = (wr_ptr - D) mod MAX_DEPTH. Computed one bit wider so
  // the add-back of MAX_DEPTH cannot overflow for non-power-of-two depths.
  always_comb begin
    wr_ext = AW'(wr_ptr_q);
    d_ext  = AW'(d_q);
    if (wr_ext >= d_ext) begin
      rd_ext = wr_ext - d_ext;
    end else begin
      rd_ext = wr_ext + AW'(MAX_DEPTH) - d_ext;
    end
    rd_addr = PW'(rd_ext);
  end

  assign wr_ptr_inc = (wr_ptr_q == PW'(MAX_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
  assign fill_inc   = fill_q + DW'(1);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    fill_d      = fill_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    mem_we      = bus.in_valid;

    if (bus.in_valid) begin
      wr_ptr_d = wr_ptr_inc;
    end

    if (bus.cfg_load) begin
      // A sample arriving with cfg_load is the first of the new configuration.
      d_d     = d_clamped;
      fill_d  = bus.in_valid ? DW'(1) : '0;
      state_d = (bus.in_valid && (d_clamped == DW'(1))) ? RUN : FILL;
    end else if (bus.in_valid) begin
      case (state_q)
        FILL: begin
          fill_d = fill_inc;
          if (fill_inc == d_q) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // Read happens before this cycle's write lands, so D=MAX_DEPTH
          // (read and write at the same address) returns the old entry.
          out_valid_d = 1'b1;
          out_data_d  = mem[rd_addr];
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      d_q         <= DW'(MAX_DEPTH);
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      fill_q      <= fill_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.fill_count = fill_q;
  assign bus.filling    = (state_q == FILL);

endmodule
